alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - single-command sequencer wrapping a combinational sign-magnitude ALU
module alu_sequencer #(
    parameter int N = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic [3:0]   in_op,
    input  logic         in_chain,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_sel,
    input  logic [N-1:0] alu_out,
    input  logic         alu_z,
    input  logic         alu_o,
    input  logic         alu_ca,
    input  logic         alu_neg,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic [3:0]   flags,
    output logic         err,
    output logic [7:0]   op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [N-1:0] acc;
    logic         accept;
    logic         capture;
    logic         retire;
    logic         op_legal;

    assign accept  = (state == IDLE) && in_valid;
    assign capture = (state == EXEC);
    assign retire  = (state == DONE) && out_ready;

    // Legal op codes are 0000..0101 and 0111..1010
    assign op_legal = (alu_sel <= 4'd5) || ((alu_sel >= 4'd7) && (alu_sel <= 4'd10));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs; the spare encoding falls back to IDLE
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand registers double as the ALU drive, so they hold outside EXEC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_sel <= 4'd0;
        end else if (accept) begin
            alu_a   <= in_chain ? acc : in_a;
            alu_b   <= in_b;
            alu_sel <= in_op;
        end
    end

    // Capture ALU response at the end of EXEC; illegal ops leave acc untouched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= '0;
            flags  <= 4'd0;
            err    <= 1'b0;
            acc    <= '0;
        end else if (capture) begin
            if (op_legal) begin
                result <= alu_out;
                flags  <= {alu_z, alu_o, alu_ca, alu_neg};
                err    <= 1'b0;
                acc    <= alu_out;
            end else begin
                result <= '0;
                flags  <= 4'd0;
                err    <= 1'b1;
            end
        end
    end

    // Completed-result counter, wraps naturally at 8 bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count <= 8'd0;
        end else if (retire) begin
            op_count <= op_count + 8'd1;
        end
    end

endmodule
